// File: rtl/out_display.sv
// out_display: bus output register with sequential double-dabble BCD conversion and a multiplexed
// active-high 7-segment display (leading-zero blanking, optional sign digit).
module out_display #(
  parameter int WIDTH       = 8,
  parameter int DIGITS      = 4,
  parameter int REFRESH_DIV = 1024
) (
  input  logic              mclk,
  input  logic              i_reset,
  input  logic              mclk_en,
  input  logic              i_load_enable,
  input  logic [WIDTH-1:0]  i_load_data,
  input  logic              i_signed_mode,
  output logic [WIDTH-1:0]  o_data,
  output logic              o_busy,
  output logic [DIGITS-1:0] o_digit_sel,
  output logic [6:0]        o_segments
);
  localparam int BW = 4 * (DIGITS - 1);
  localparam int CW = WIDTH > 1 ? $clog2(WIDTH) : 1;
  localparam int RW = REFRESH_DIV > 1 ? $clog2(REFRESH_DIV) : 1;
  localparam int SW = $clog2(DIGITS);
  localparam logic IDLE = 1'b0;
  localparam logic CONV = 1'b1;

  logic              state;
  logic [CW-1:0]     cnt;
  logic [WIDTH-1:0]  mag;
  logic [BW-1:0]     bcd, bcd_adj, bcd_nxt, disp_bcd;
  logic              sign_c, disp_sign;
  logic [RW-1:0]     ref_cnt;
  logic [SW-1:0]     scan;
  logic [4*DIGITS-1:0] ext;
  logic [3:0]        nib;
  logic              load, neg, wrap, blank, last;
  logic [WIDTH-1:0]  mag_in;

  assign load   = mclk_en & i_load_enable;
  assign neg    = i_signed_mode & i_load_data[WIDTH-1];
  assign mag_in = neg ? -i_load_data : i_load_data;
  assign wrap   = ref_cnt == RW'(REFRESH_DIV - 1);
  assign o_busy = state == CONV;

  for (genvar i = 0; i < DIGITS - 1; i++) begin : g_adj
    assign bcd_adj[4*i +: 4] = bcd[4*i +: 4] >= 4'd5 ? bcd[4*i +: 4] + 4'd3 : bcd[4*i +: 4];
  end
  assign bcd_nxt = {bcd_adj[BW-2:0], mag[WIDTH-1]};

  always_ff @(posedge mclk) begin
    if (i_reset) begin
      state     <= IDLE;
      cnt       <= '0;
      mag       <= '0;
      bcd       <= '0;
      sign_c    <= 1'b0;
      o_data    <= '0;
      disp_bcd  <= '0;
      disp_sign <= 1'b0;
      ref_cnt   <= '0;
      scan      <= '0;
    end else begin
      ref_cnt <= wrap ? '0 : ref_cnt + 1'b1;
      if (wrap) scan <= scan == SW'(DIGITS - 1) ? '0 : scan + 1'b1;
      if (load) begin
        o_data <= i_load_data;
        sign_c <= neg;
        mag    <= mag_in;
        bcd    <= '0;
        cnt    <= '0;
        state  <= CONV;
      end else if (state == CONV) begin
        mag <= {mag[WIDTH-2:0], 1'b0};
        bcd <= bcd_nxt;
        cnt <= cnt + 1'b1;
        if (cnt == CW'(WIDTH - 1)) begin
          state     <= IDLE;
          disp_bcd  <= bcd_nxt;
          disp_sign <= sign_c;
        end
      end
    end
  end

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0: seg7 = 7'h3F;
      4'd1: seg7 = 7'h06;
      4'd2: seg7 = 7'h5B;
      4'd3: seg7 = 7'h4F;
      4'd4: seg7 = 7'h66;
      4'd5: seg7 = 7'h6D;
      4'd6: seg7 = 7'h7D;
      4'd7: seg7 = 7'h07;
      4'd8: seg7 = 7'h7F;
      4'd9: seg7 = 7'h6F;
      default: seg7 = 7'h00;
    endcase
  endfunction

  // A digit is blank when it and every more significant magnitude digit are zero.
  assign ext         = {4'h0, disp_bcd};
  assign nib         = ext[4*scan +: 4];
  assign blank       = scan != '0 && (ext >> (4 * scan)) == '0;
  assign last        = scan == SW'(DIGITS - 1);
  assign o_digit_sel = DIGITS'(1) << scan;
  assign o_segments  = last ? (disp_sign ? 7'h40 : 7'h00) : blank ? 7'h00 : seg7(nib);
endmodule

// File: tb/tb_out_display.sv
// tb_out_display: randomized and directed stimulus against a decimal-arithmetic reference model.
module tb_out_display;
  logic       mclk = 1'b0;
  logic       i_reset = 1'b1;
  logic       mclk_en = 1'b0;
  logic       i_load_enable = 1'b0;
  logic [7:0] i_load_data = '0;
  logic       i_signed_mode = 1'b0;
  logic [7:0] o_data;
  logic       o_busy;
  logic [3:0] o_digit_sel;
  logic [6:0] o_segments;

  out_display #(.WIDTH(8), .DIGITS(4), .REFRESH_DIV(4)) dut (
    .mclk(mclk), .i_reset(i_reset), .mclk_en(mclk_en), .i_load_enable(i_load_enable),
    .i_load_data(i_load_data), .i_signed_mode(i_signed_mode), .o_data(o_data),
    .o_busy(o_busy), .o_digit_sel(o_digit_sel), .o_segments(o_segments)
  );

  always #5 mclk = ~mclk;

  int n_chk = 0;
  int n_err = 0;

  int m_data, m_left, m_pend_val, m_disp_val, m_tick;
  bit m_pend_sign, m_disp_sign;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [6:0] digit_code(input int v);
    logic [6:0] t [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
    return t[v];
  endfunction

  function automatic logic [6:0] exp_seg(input int d);
    int p = 1;
    if (d == 3) return m_disp_sign ? 7'h40 : 7'h00;
    for (int k = 0; k < d; k++) p *= 10;
    if (d > 0 && m_disp_val / p == 0) return 7'h00;
    return digit_code((m_disp_val / p) % 10);
  endfunction

  // One mclk edge: drive inputs, advance the model, then compare everything 1 time unit later.
  task automatic step(input bit rst, input bit en, input bit ld, input logic [7:0] d, input bit sgn);
    int scan;
    i_reset = rst; mclk_en = en; i_load_enable = ld; i_load_data = d; i_signed_mode = sgn;
    @(posedge mclk);
    if (rst) begin
      m_data = 0; m_left = 0; m_disp_val = 0; m_disp_sign = 0; m_tick = 0;
    end else begin
      m_tick++;
      if (en && ld) begin
        m_data = d;
        m_pend_sign = sgn && d[7];
        m_pend_val = m_pend_sign ? 256 - int'(d) : int'(d);
        m_left = 8;
      end else if (m_left > 0) begin
        m_left--;
        if (m_left == 0) begin
          m_disp_val = m_pend_val;
          m_disp_sign = m_pend_sign;
        end
      end
    end
    #1;
    scan = (m_tick / 4) % 4;
    check("data", o_data, m_data);
    check("busy", o_busy, m_left > 0);
    check("digit_sel", o_digit_sel, 32'(1) << scan);
    check("segments", o_segments, exp_seg(scan));
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(0, 1, 0, 8'h00, 0);
  endtask

  task automatic load(input logic [7:0] d, input bit sgn);
    step(0, 1, 1, d, sgn);
  endtask

  initial begin
    step(1, 0, 0, 8'h00, 0);
    step(1, 1, 1, 8'h55, 0);
    idle(16);
    load(8'd123, 0); idle(26);
    load(8'h80, 1); idle(26);
    load(8'hFB, 1); idle(26);
    load(8'd200, 0); idle(2); load(8'd7, 0); idle(26);
    for (int k = 0; k < 20; k++) step(0, 0, 1, 8'($urandom), 1'($urandom));
    load(8'd99, 0); idle(3);
    step(1, 1, 0, 8'h00, 0); idle(20);
    load(8'hFF, 1); idle(7); load(8'h01, 0); idle(12);
    for (int k = 0; k < 600; k++) begin
      int r = int'($urandom_range(0, 127));
      step(r == 0, 1'($urandom), r < 16, 8'($urandom), 1'($urandom));
    end
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
